// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared FSM state type and default widths for the Gray converter
package gray_conv_pkg;
    typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/gray_conv_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, pointer moves past the winner on every grant
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic ptr;
    // Lone requester wins outright; on contention the pointer picks the winner
    always_comb o_gnt = !(i_en && i_rst_n) ? 2'b00 : &i_req ? (ptr ? 2'b10 : 2'b01) : i_req;
    // After granting requester 0 favour 1 next, and vice versa
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) ptr <= 1'b0;
        else if (|o_gnt) ptr <= o_gnt[0];
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: arbitrates two Gray-word requesters and returns the binary value
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0_valid,
    input  logic [WIDTH-1:0] i_req0_gray,
    output logic             o_req0_ready,
    input  logic             i_req1_valid,
    input  logic [WIDTH-1:0] i_req1_gray,
    output logic             o_req1_ready,
    output logic             o_rsp_valid,
    output logic [WIDTH-1:0] o_rsp_binary,
    output logic             o_rsp_id,
    input  logic             i_rsp_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_done_cnt
);
    state_t           state, state_nxt;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] gray_q, bin_d, bin_q;
    logic             id_q;
    logic [CNT_W-1:0] done_cnt;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (state == IDLE),
        .i_req   ({i_req1_valid, i_req0_valid}),
        .o_gnt   (gnt)
    );

    assign o_req0_ready = gnt[0];
    assign o_req1_ready = gnt[1];
    assign o_rsp_valid  = state == RESP;
    assign o_rsp_binary = bin_q;
    assign o_rsp_id     = id_q;
    assign o_busy       = state != IDLE;
    assign o_done_cnt   = done_cnt;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else state <= state_nxt;

    // Grant moves to CONV, CONV always lasts one cycle, RESP waits for the consumer
    always_comb begin
        state_nxt = IDLE;
        state_nxt = state == IDLE ? (|gnt ? CONV : IDLE) :
                    state == CONV ? RESP :
                    (state == RESP && !i_rsp_ready) ? RESP : IDLE;
    end

    // Binary bit k is the parity of Gray bits k and above
    always_comb begin
        bin_d = '0;
        for (int k = 0; k < WIDTH; k++) bin_d[k] = ^(gray_q >> k);
    end

    // Capture on grant, convert in CONV, count on consumer handshake
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            gray_q   <= '0;
            id_q     <= 1'b0;
            bin_q    <= '0;
            done_cnt <= '0;
        end else begin
            if (|gnt) begin
                gray_q <= gnt[1] ? i_req1_gray : i_req0_gray;
                id_q   <= gnt[1];
            end
            if (state == CONV) bin_q <= bin_d;
            if (state == RESP && i_rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
        end
endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, sets the Gray/binary word width in bits.
REQ-002 Parameter CNT_W, default 8, sets the completed-conversion counter width.
REQ-003 Port i_clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n  input  1  is the reset: asynchronous assert, active-low.
REQ-005 Port i_req0_valid  input  1  means requester 0 offers a Gray word.
REQ-006 Port i_req0_gray  input  WIDTH  is requester 0's Gray word.
REQ-007 Port o_req0_ready  output  1  means requester 0's word is accepted this cycle.
REQ-008 Ports i_req1_valid, i_req1_gray, o_req1_ready SHALL mirror REQ-005..007 for requester 1.
REQ-009 Port o_rsp_valid  output  1  means a converted result is presented.
REQ-010 Port o_rsp_binary  output  WIDTH  is the binary result.
REQ-011 Port o_rsp_id  output  1  is the requester index that produced the result.
REQ-012 Port i_rsp_ready  input  1  means the consumer takes the result this cycle.
REQ-013 Port o_busy  output  1  is high in any state other than IDLE.
REQ-014 Port o_done_cnt  output  CNT_W  counts completed responses.

Function
REQ-015 FSM states SHALL be IDLE, CONV and RESP; exactly one is active.
REQ-016 IDLE: if any valid is high, grant one requester, assert its ready combinationally in that cycle, latch its Gray word and id, and go to CONV.
REQ-017 Ready SHALL be high only in IDLE, only for the granted requester, and never for both.
REQ-018 Arbitration: single valid wins; when both are valid, the round-robin pointer wins and the pointer then points to the other requester.
REQ-019 The pointer SHALL update only on a grant and SHALL favour requester 0 after reset.
REQ-020 CONV (one cycle): register binary[WIDTH-1] = gray[WIDTH-1] and binary[k] = binary[k+1] XOR gray[k] for k below WIDTH-1, then go to RESP.
REQ-021 RESP: hold o_rsp_valid high with o_rsp_binary and o_rsp_id stable until i_rsp_ready is high.
REQ-022 When i_rsp_ready is high in RESP, return to IDLE on the next edge and increment o_done_cnt, wrapping from all-ones to 0.
REQ-023 When the consumer is always ready, the accept-to-o_rsp_valid latency SHALL be 2 cycles and throughput one word per 3 cycles.
REQ-024 Valid, data and i_rsp_ready changes while in CONV or RESP SHALL have no effect; requesters hold valid and data until ready is seen.
REQ-025 i_rsp_ready while o_rsp_valid is low SHALL be ignored.

Reset
REQ-026 While i_rst_n is low: state is IDLE, pointer is 0, all ready and o_rsp_valid are 0, o_rsp_binary is 0, o_rsp_id is 0, o_busy is 0, o_done_cnt is 0.
REQ-027 Reset asserted mid-conversion or mid-response SHALL discard the transaction without a response and without a counter increment.
REQ-028 No grant SHALL occur in the first cycle after i_rst_n deasserts unless valid is high at that edge.

Structure
REQ-029 A shared package gray_conv_pkg SHALL hold the FSM state enum and the default WIDTH/CNT_W constants.
REQ-030 Two-way round-robin grant logic SHALL be one sub-module, rr_arb2; Gray decode stays inline.

Verification
REQ-031 Basic flow: req0 gray 0110, consumer ready -> ready0 in cycle 0; rsp_valid in cycle 2 with binary 0100, id 0; o_done_cnt = 1.
REQ-032 Contention: both valid from reset, gray0 1000 and gray1 1111 -> req0 served first (binary 1111, id 0), then req1 (binary 1010, id 1).
REQ-033 Back-pressure: i_rsp_ready held low for 5 cycles with gray 0111 -> rsp_valid held and binary stays 0101; no new ready is issued; completes when ready rises.
REQ-034 Fairness: both valid continuously for 6 transactions -> ids alternate 0,1,0,1,0,1.
REQ-035 Reset mid-RESP: i_rst_n pulsed low while rsp_valid is high -> all outputs go to 0 immediately and o_done_cnt is unchanged at 0.
REQ-036 Counter wrap: CNT_W=2 with 5 completions -> o_done_cnt sequence 1,2,3,0,1.
